// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud encodings, rx state codes and divisor helper
package uart_pkg;

    // Baud-select encodings, identical on the TX side
    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    // Width of the oversample divisor counter
    localparam int DIV_W = 12;

    // Receiver FSM state codes
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t RX_IDLE   = 3'd0;
    localparam rx_state_t RX_START  = 3'd1;
    localparam rx_state_t RX_DATA   = 3'd2;
    localparam rx_state_t RX_PARITY = 3'd3;
    localparam rx_state_t RX_STOP   = 3'd4;
    localparam rx_state_t RX_BRK    = 3'd5;

    // Baud rate in bits per second for a select code
    function automatic int baud_rate(input logic [1:0] sel);
        case (sel)
            BAUD_2400:  return 2400;
            BAUD_4800:  return 4800;
            BAUD_9600:  return 9600;
            default:    return 19200;
        endcase
    endfunction

    // Clocks per oversample tick, rounded to nearest
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq,
                                                  input int oversample,
                                                  input logic [1:0] sel);
        int den;
        den = oversample * baud_rate(sel);
        return DIV_W'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// rtl/uart_rx_tick_gen.sv - oversample tick generator with synchronous clear
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic             at_top;

    assign at_top = (cnt == (div - DIV_W'(1)));

    // A clear suppresses the tick so the new bit period starts cleanly
    assign tick = at_top & ~clear;

    // Divisor counter: wraps to 0 after reaching div-1, restarts on clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || at_top) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with parity, frame and overrun flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           baud_sel,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int              OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

    localparam logic [DIV_W-1:0] DIV_2400  = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_2400);
    localparam logic [DIV_W-1:0] DIV_4800  = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_4800);
    localparam logic [DIV_W-1:0] DIV_9600  = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_9600);
    localparam logic [DIV_W-1:0] DIV_19200 = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_19200);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic [OS_W-1:0]      os_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [1:0]           baud_lat;
    logic [DIV_W-1:0]     div;
    logic                 tick;
    logic                 start_det;
    logic                 os_wrap;
    logic                 perr;
    logic                 ferr;
    logic                 deliver;
    logic                 accept;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Divisor for the baud rate latched at the start of the current frame
    always_comb begin
        div = DIV_19200;
        case (baud_lat)
            BAUD_2400: div = DIV_2400;
            BAUD_4800: div = DIV_4800;
            BAUD_9600: div = DIV_9600;
            default:   div = DIV_19200;
        endcase
    end

    assign start_det = (state == RX_IDLE) && !rx_s;
    assign os_wrap   = tick && (os_cnt == OS_LAST);
    assign busy      = (state != RX_IDLE);
    assign accept    = rx_valid & rx_ready;

    uart_rx_tick_gen u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (start_det),
        .div   (div),
        .tick  (tick)
    );

    // Frame FSM: start validation, data shift, parity, stop and break handling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            baud_lat <= BAUD_2400;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            deliver  <= 1'b0;
        end else begin
            deliver <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        os_cnt   <= '0;
                        bit_cnt  <= '0;
                        perr     <= 1'b0;
                        baud_lat <= baud_sel;
                        state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (os_cnt == OS_MID) begin
                            os_cnt <= '0;
                            state  <= rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            os_cnt <= os_cnt + OS_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (os_wrap) begin
                        os_cnt  <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= parity_en ? RX_PARITY : RX_STOP;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (os_wrap) begin
                        os_cnt <= '0;
                        perr   <= rx_s ^ (^shreg) ^ parity_odd;
                        state  <= RX_STOP;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                RX_STOP: begin
                    if (os_wrap) begin
                        os_cnt  <= '0;
                        ferr    <= !rx_s;
                        deliver <= 1'b1;
                        state   <= rx_s ? RX_IDLE : RX_BRK;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                RX_BRK: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

    // Output register: load on deliver if the slot is free, otherwise flag overrun
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data    <= shreg;
                frame_err  <= ferr;
                parity_err <= perr;
                rx_valid   <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end

            if (deliver && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
